// File: rtl/video_cfg_shadow.sv
// Double-buffered video configuration bank: MCU writes land in shadow words and are copied
// atomically to the active bank on flyback (or timeout/force), then announced by a req/ack handshake.
module video_cfg_shadow #(
    parameter int NUM_REGS    = 11,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 20,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                reg_wdata,
    output logic [31:0]                reg_rdata,
    input  logic [ADDR_W-1:0]          reg_addr,
    input  logic                       reg_wstrobe,
    input  logic                       flybk_async,
    input  logic                       cfg_ack_async,
    output logic [NUM_REGS*DATA_W-1:0] active_regs,
    output logic                       cfg_req,
    output logic                       commit_pending,
    output logic                       irq
);

    localparam int WORD_W = ADDR_W - 2;
    localparam logic [WORD_W-1:0] CTRL_IDX = WORD_W'(NUM_REGS);
    localparam logic [WORD_W-1:0] CNT_IDX  = WORD_W'(NUM_REGS + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FLY,
        APPLY,
        REQ,
        REL
    } state_t;

    state_t                state_reg, state_next;
    logic [TIMEOUT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic                  cfg_req_reg, cfg_req_next;
    logic                  apply;
    logic                  timeout_set;

    logic [SYNC_STAGES-1:0] flybk_sync_reg;
    logic [SYNC_STAGES-1:0] ack_sync_reg;
    logic                   flybk_prev_reg;
    logic                   flybk_s;
    logic                   cfg_ack_s;
    logic                   fly_edge;

    logic                   done_reg;
    logic                   timeout_reg;
    logic                   irq_en_reg;
    logic                   irq_reg;
    logic [15:0]            commit_cnt_reg;

    logic [DATA_W-1:0]      shadow_reg [NUM_REGS];
    logic [DATA_W-1:0]      active_reg [NUM_REGS];
    logic [31:0]            shadow_ext [NUM_REGS];
    logic [DATA_W-1:0]      wr_word;

    logic [WORD_W-1:0]      word_idx;
    logic                   ctrl_wr;
    logic                   addr_unused;

    assign word_idx    = reg_addr[ADDR_W-1:2];
    assign addr_unused = &{1'b0, reg_addr[1:0]};
    assign ctrl_wr     = reg_wstrobe && (word_idx == CTRL_IDX);
    // Size cast truncates or zero-extends the bus word to the configured width.
    assign wr_word     = DATA_W'(reg_wdata);

    // ---------------------------------------------------------------- synchronisers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flybk_sync_reg <= '0;
            ack_sync_reg   <= '0;
            flybk_prev_reg <= 1'b0;
        end else begin
            flybk_sync_reg <= {flybk_sync_reg[SYNC_STAGES-2:0], flybk_async};
            ack_sync_reg   <= {ack_sync_reg[SYNC_STAGES-2:0], cfg_ack_async};
            flybk_prev_reg <= flybk_s;
        end
    end

    assign flybk_s   = flybk_sync_reg[SYNC_STAGES-1];
    assign cfg_ack_s = ack_sync_reg[SYNC_STAGES-1];
    assign fly_edge  = flybk_s && !flybk_prev_reg;

    // ---------------------------------------------------------------- register banks
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bank
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    shadow_reg[gi] <= RESET_VAL[gi*DATA_W +: DATA_W];
                    active_reg[gi] <= RESET_VAL[gi*DATA_W +: DATA_W];
                end else begin
                    if (reg_wstrobe && (word_idx == WORD_W'(gi))) begin
                        shadow_reg[gi] <= wr_word;
                    end
                    // Non-blocking copy: a shadow write in the same cycle is not seen here.
                    if (apply) begin
                        active_reg[gi] <= shadow_reg[gi];
                    end
                end
            end

            assign active_regs[gi*DATA_W +: DATA_W] = active_reg[gi];
            assign shadow_ext[gi] = 32'(shadow_reg[gi]);
        end
    endgenerate

    // ---------------------------------------------------------------- read mux
    always_comb begin
        reg_rdata = '0;
        if (word_idx == CTRL_IDX) begin
            reg_rdata = {24'h0, cfg_ack_s, cfg_req_reg, flybk_s, done_reg,
                         timeout_reg, irq_en_reg, 1'b0, commit_pending};
        end else if (word_idx == CNT_IDX) begin
            reg_rdata = {16'h0, commit_cnt_reg};
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (word_idx == WORD_W'(i)) begin
                    reg_rdata = shadow_ext[i];
                end
            end
        end
    end

    // ---------------------------------------------------------------- commit FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            cfg_req_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            cfg_req_reg  <= cfg_req_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        cfg_req_next  = cfg_req_reg;
        apply         = 1'b0;
        timeout_set   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ctrl_wr && reg_wdata[1]) begin
                    state_next    = APPLY;
                    wait_cnt_next = '0;
                end else if (ctrl_wr && reg_wdata[0]) begin
                    state_next    = WAIT_FLY;
                    wait_cnt_next = '0;
                end
            end
            WAIT_FLY: begin
                wait_cnt_next = wait_cnt_reg + 1'b1;
                // A real flyback edge wins over a simultaneous terminal count.
                if (fly_edge) begin
                    state_next = APPLY;
                end else if (&wait_cnt_next) begin
                    state_next  = APPLY;
                    timeout_set = 1'b1;
                end
            end
            APPLY: begin
                apply        = 1'b1;
                cfg_req_next = 1'b1;
                state_next   = REQ;
            end
            REQ: begin
                if (cfg_ack_s) begin
                    cfg_req_next = 1'b0;
                    state_next   = REL;
                end
            end
            REL: begin
                if (!cfg_ack_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                cfg_req_next = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------- status and interrupt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            irq_en_reg     <= 1'b0;
            irq_reg        <= 1'b0;
            commit_cnt_reg <= '0;
        end else begin
            if (ctrl_wr) begin
                irq_en_reg <= reg_wdata[2];
            end
            // Set has priority over write-one-to-clear.
            if (apply) begin
                done_reg <= 1'b1;
            end else if (ctrl_wr && reg_wdata[4]) begin
                done_reg <= 1'b0;
            end
            if (timeout_set) begin
                timeout_reg <= 1'b1;
            end else if (ctrl_wr && reg_wdata[3]) begin
                timeout_reg <= 1'b0;
            end
            if (apply) begin
                commit_cnt_reg <= commit_cnt_reg + 16'd1;
            end
            irq_reg <= irq_en_reg && (done_reg || timeout_reg);
        end
    end

    assign cfg_req        = cfg_req_reg;
    assign commit_pending = (state_reg != IDLE);
    assign irq            = irq_reg;

endmodule

// File: tb/tb_video_cfg_shadow.sv
// Directed testbench for video_cfg_shadow: reset, aligned commit, handshake, timeout,
// force race, bounds, back-to-back commits and reset abort.
module tb_video_cfg_shadow;

    localparam int NUM_REGS    = 11;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 6;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_W   = 8;
    localparam logic [NUM_REGS*DATA_W-1:0] RV =
        {{9{32'h0}}, 32'h0000_BEEF, 32'hCAFE_0001};
    localparam logic [5:0] CTRL_A = 6'd44;
    localparam logic [5:0] CNT_A  = 6'd48;

    logic                       clk;
    logic                       reset;
    logic [31:0]                reg_wdata;
    logic [31:0]                reg_rdata;
    logic [ADDR_W-1:0]          reg_addr;
    logic                       reg_wstrobe;
    logic                       flybk_async;
    logic                       cfg_ack_async;
    logic [NUM_REGS*DATA_W-1:0] active_regs;
    logic                       cfg_req;
    logic                       commit_pending;
    logic                       irq;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    video_cfg_shadow #(
        .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_W(TIMEOUT_W), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .reset(reset), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .reg_addr(reg_addr), .reg_wstrobe(reg_wstrobe), .flybk_async(flybk_async),
        .cfg_ack_async(cfg_ack_async), .active_regs(active_regs), .cfg_req(cfg_req),
        .commit_pending(commit_pending), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_reg(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_addr = a; reg_wdata = d; reg_wstrobe = 1'b1;
        @(negedge clk);
        reg_wstrobe = 1'b0;
    endtask

    task automatic read_reg(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        reg_addr = a;
        #1 d = reg_rdata;
    endtask

    task automatic wait_req(input logic lvl, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (cfg_req === lvl) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (commit_pending === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_handshake(output bit ok);
        bit o1, o2, o3;
        wait_req(1'b1, 400, o1);
        cfg_ack_async = 1'b1;
        wait_req(1'b0, 20, o2);
        cfg_ack_async = 1'b0;
        wait_idle(20, o3);
        ok = o1 & o2 & o3;
    endtask

    function automatic logic [31:0] act_word(input int i);
        return active_regs[i*32 +: 32];
    endfunction

    task automatic test_reset;
        logic [31:0] d;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (active_regs !== RV) begin bad++; $display("FAIL reset_hold_active got=%h exp=%h", active_regs, RV); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (active_regs !== RV) begin bad++; $display("FAIL reset_active got=%h exp=%h", active_regs, RV); end
        read_reg(CTRL_A, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", d); end
        read_reg(CNT_A, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", d); end
        read_reg(6'd4, d);
        total++; if (d !== 32'h0000_BEEF) begin bad++; $display("FAIL reset_shadow1 got=%h exp=0000beef", d); end
        total++; if ({cfg_req, irq, commit_pending} !== 3'b000) begin bad++; $display("FAIL reset_outs got=%b exp=000", {cfg_req, irq, commit_pending}); end
    endtask

    task automatic test_aligned_commit;
        logic [31:0] d;
        write_reg(6'd0, 32'h8000_0280);
        write_reg(CTRL_A, 32'h1);
        repeat (100) @(negedge clk);
        total++; if (act_word(0) !== 32'hCAFE_0001) begin bad++; $display("FAIL aligned_hold got=%h exp=cafe0001", act_word(0)); end
        total++; if (commit_pending !== 1'b1) begin bad++; $display("FAIL aligned_pending got=%b exp=1", commit_pending); end
        flybk_async = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (act_word(0) !== 32'hCAFE_0001) begin bad++; $display("FAIL aligned_early got=%h exp=cafe0001", act_word(0)); end
        @(negedge clk);
        total++; if (act_word(0) !== 32'h8000_0280) begin bad++; $display("FAIL aligned_latency got=%h exp=80000280", act_word(0)); end
        exp_cnt++;
        read_reg(CNT_A, d);
        total++; if (d !== 32'(exp_cnt)) begin bad++; $display("FAIL aligned_cnt got=%0d exp=%0d", d, exp_cnt); end
        read_reg(CTRL_A, d);
        total++; if (d !== 32'h71) begin bad++; $display("FAIL aligned_ctrl got=%h exp=71", d); end
    endtask

    task automatic test_handshake;
        logic [31:0] d;
        write_reg(CTRL_A, 32'h1);
        flybk_async = 1'b0;
        cfg_ack_async = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (cfg_req !== 1'b0) begin bad++; $display("FAIL hs_req_fall got=%b exp=0", cfg_req); end
        total++; if (commit_pending !== 1'b1) begin bad++; $display("FAIL hs_rel_pending got=%b exp=1", commit_pending); end
        cfg_ack_async = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (commit_pending !== 1'b0) begin bad++; $display("FAIL hs_idle got=%b exp=0", commit_pending); end
        read_reg(CNT_A, d);
        total++; if (d !== 32'(exp_cnt)) begin bad++; $display("FAIL hs_cnt got=%0d exp=%0d", d, exp_cnt); end
    endtask

    task automatic test_timeout;
        logic [31:0] d;
        bit ok;
        write_reg(CTRL_A, 32'h4);
        write_reg(6'd0, 32'h0000_0AAA);
        write_reg(CTRL_A, 32'h5);
        repeat (200) @(negedge clk);
        total++; if ({commit_pending, cfg_req} !== 2'b10) begin bad++; $display("FAIL to_wait got=%b exp=10", {commit_pending, cfg_req}); end
        wait_req(1'b1, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_apply got=timeout exp=cfg_req"); end
        exp_cnt++;
        total++; if (act_word(0) !== 32'h0000_0AAA) begin bad++; $display("FAIL to_active got=%h exp=00000aaa", act_word(0)); end
        read_reg(CTRL_A, d);
        total++; if (d !== 32'h5D) begin bad++; $display("FAIL to_ctrl got=%h exp=5d", d); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL to_irq got=%b exp=1", irq); end
        do_handshake(ok);
        total++; if (!ok) begin bad++; $display("FAIL to_handshake got=stuck exp=idle"); end
        write_reg(CTRL_A, 32'h1C);
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL to_irq_clear got=%b exp=0", irq); end
        read_reg(CTRL_A, d);
        total++; if (d !== 32'h04) begin bad++; $display("FAIL to_w1c got=%h exp=04", d); end
    endtask

    task automatic test_force_race;
        logic [31:0] d;
        bit ok;
        @(negedge clk);
        reg_addr = CTRL_A; reg_wdata = 32'h2; reg_wstrobe = 1'b1;
        @(negedge clk);
        reg_addr = 6'd4; reg_wdata = 32'h1234_5678;
        @(negedge clk);
        reg_wstrobe = 1'b0;
        exp_cnt++;
        total++; if (act_word(1) !== 32'h0000_BEEF) begin bad++; $display("FAIL race_active1 got=%h exp=0000beef", act_word(1)); end
        read_reg(6'd4, d);
        total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL race_shadow1 got=%h exp=12345678", d); end
        do_handshake(ok);
        total++; if (!ok) begin bad++; $display("FAIL race_hs1 got=stuck exp=idle"); end
        write_reg(CTRL_A, 32'h2);
        exp_cnt++;
        do_handshake(ok);
        total++; if (!ok) begin bad++; $display("FAIL race_hs2 got=stuck exp=idle"); end
        total++; if (act_word(1) !== 32'h1234_5678) begin bad++; $display("FAIL race_active2 got=%h exp=12345678", act_word(1)); end
    endtask

    task automatic test_bounds;
        logic [31:0] d;
        write_reg(6'd56, 32'hFFFF_FFFF);
        write_reg(6'd60, 32'hFFFF_FFFF);
        read_reg(6'd56, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL bounds_read got=%h exp=0", d); end
        read_reg(6'd0, d);
        total++; if (d !== 32'h0000_0AAA) begin bad++; $display("FAIL bounds_shadow0 got=%h exp=00000aaa", d); end
        read_reg(CTRL_A, d);
        total++; if (d !== 32'h10) begin bad++; $display("FAIL bounds_ctrl got=%h exp=10", d); end
        total++; if (commit_pending !== 1'b0) begin bad++; $display("FAIL bounds_pending got=%b exp=0", commit_pending); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        bit ok;
        for (int k = 0; k < 20; k++) begin
            write_reg(6'd0, 32'h5000_0000 + 32'(k));
            write_reg(CTRL_A, 32'h2);
            exp_cnt++;
            do_handshake(ok);
            total++; if (!ok || act_word(0) !== 32'h5000_0000 + 32'(k)) begin
                bad++; $display("FAIL b2b_%0d got=%h ok=%0d exp=%h", k, act_word(0), ok, 32'h5000_0000 + 32'(k));
            end
        end
        read_reg(CNT_A, d);
        total++; if (d !== 32'(exp_cnt)) begin bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", d, exp_cnt); end
    endtask

    task automatic test_reset_abort;
        logic [31:0] d;
        bit ok;
        write_reg(CTRL_A, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (commit_pending !== 1'b0 || active_regs !== RV) begin bad++; $display("FAIL abort_wait got=%b/%h exp=0/%h", commit_pending, active_regs, RV); end
        @(negedge clk);
        reset = 1'b1;
        write_reg(CTRL_A, 32'h2);
        wait_req(1'b1, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL abort_req got=timeout exp=cfg_req"); end
        reset = 1'b0;
        #1;
        total++; if (cfg_req !== 1'b0 || commit_pending !== 1'b0) begin bad++; $display("FAIL abort_hs got=%b%b exp=00", cfg_req, commit_pending); end
        @(negedge clk);
        reset = 1'b1;
        read_reg(CNT_A, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL abort_cnt got=%0d exp=0", d); end
    endtask

    initial begin
        reset = 1'b0;
        reg_wdata = '0;
        reg_addr = '0;
        reg_wstrobe = 1'b0;
        flybk_async = 1'b0;
        cfg_ack_async = 1'b0;
        test_reset;
        test_aligned_commit;
        test_handshake;
        test_timeout;
        test_force_race;
        test_bounds;
        test_back_to_back;
        test_reset_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_cfg_shadow.md
Name: video_cfg_shadow

Overview:
- Parametrised, double-buffered register bank for the video output configuration, sitting between the MCU register bus and the pixel-domain timing generator.
- MCU writes land in shadow registers. A commit request copies every shadow register into the active set in one cycle, aligned to the next VIDC flyback rising edge, with a timeout fallback.
- After the copy, a 4-phase req/ack handshake tells the consumer domain that new config is stable.
- Adds what a single-bank config block lacks: atomic multi-register update, flyback alignment, timeout, sticky status and interrupt.

Parameters:
- NUM_REGS, 11, number of shadow/active configuration words.
- DATA_W, 32, width of each configuration word.
- ADDR_W, 6, byte address width; bits [1:0] ignored; must cover NUM_REGS+2 words.
- SYNC_STAGES, 2, flip-flops in each async input synchroniser (minimum 2).
- TIMEOUT_W, 20, width of the flyback-wait counter.
- RESET_VAL, {NUM_REGS*DATA_W{1'b0}}, reset contents of both shadow and active banks; word i at bits [i*DATA_W +: DATA_W].

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- reg_wdata  in  32  MCU write data.
- reg_rdata  out  32  MCU read data, combinational from reg_addr.
- reg_addr  in  ADDR_W  MCU byte address.
- reg_wstrobe  in  1  single-cycle write enable.
- flybk_async  in  1  VIDC flyback, asynchronous.
- cfg_ack_async  in  1  consumer acknowledge, asynchronous.
- active_regs  out  NUM_REGS*DATA_W  active configuration bank.
- cfg_req  out  1  "new config stable" request to the consumer.
- commit_pending  out  1  high whenever the FSM is not IDLE.
- irq  out  1  level interrupt.

Behaviour:
Register map (word index w = reg_addr[ADDR_W-1:2]):
- w < NUM_REGS: shadow word. Read/write.
- w == NUM_REGS: CTRL register.
  - Write: bit0 commit, bit1 force (commit without waiting for flyback), bit2 irq_en (stored), bit3 W1C timeout sticky, bit4 W1C done sticky.
  - Read: {24'h0, cfg_ack_s, cfg_req, flybk_s, done, timeout, irq_en, 1'b0, pending}.
- w == NUM_REGS+1: commit counter in bits [15:0], read-only; 16-bit, wraps 0xFFFF -> 0.
- Any other w: reads 0, writes ignored.
- When DATA_W < 32, shadow reads zero-extend and writes truncate.

Reset (reset low, asynchronous):
- shadow and active_regs = RESET_VAL.
- FSM = IDLE; cfg_req=0; sticky bits, irq_en, counters = 0.
- Synchroniser flops = 0; irq=0, commit_pending=0.
- Asserting reset mid-commit or mid-handshake aborts immediately to these values.

Synchronisers:
- flybk_async and cfg_ack_async each pass through SYNC_STAGES flops, giving flybk_s and cfg_ack_s.
- A flyback edge is flybk_s==1 with its previous registered value ==0.

FSM states:
- IDLE: CTRL write with commit=1 -> WAIT_FLY and clear the timeout counter. If force=1 as well (or force alone) -> APPLY. Commit/force writes in any other state are ignored.
- WAIT_FLY: the timeout counter increments each cycle.
  - Flyback edge -> APPLY.
  - Else, counter reaching all-ones -> APPLY and set the timeout sticky.
  - Edge and terminal count in the same cycle -> APPLY with no timeout flag.
- APPLY (exactly one cycle): on the edge leaving it, active_regs <= shadow, done sticky <= 1, commit counter +1, cfg_req <= 1, next state REQ.
  - A shadow write in the APPLY cycle updates the shadow only; active gets the pre-write value.
- REQ: hold cfg_req=1 until cfg_ack_s==1; then cfg_req <= 0 and go to REL.
- REL: wait until cfg_ack_s==0, then go to IDLE.

Shadow writes are accepted in every state.

Sticky bits: a set and a W1C in the same cycle resolves as set.

irq = irq_en & (done | timeout), registered.

Latency: flybk_async high, stable and sampled at edge E while in WAIT_FLY -> active_regs updates at edge E+SYNC_STAGES+1.

Test Plan:
- Reset values: hold reset low, then release -> active_regs==RESET_VAL, reads of word NUM_REGS and NUM_REGS+1 return 0, cfg_req=0, irq=0.
- Aligned commit: write shadow[0]=0x80000280, write CTRL=0x1, keep flyback low for 100 cycles -> active unchanged and pending=1. Raise flyback -> active word0=0x80000280 exactly 3 edges after flyback is sampled; counter=1; cfg_req=1.
- Handshake: after cfg_req=1, raise ack -> cfg_req falls 2-3 cycles later. Lower ack -> pending clears. A commit written during REQ is ignored and the counter stays 1.
- Timeout: TIMEOUT_W=4, commit with flyback held low -> APPLY after 15 cycles, CTRL bit3=1. With irq_en=1, irq=1. Write CTRL=0x18 -> irq=0.
- Force plus race: write CTRL=0x2 while also writing shadow[1] in the APPLY cycle -> active word1 holds the old shadow value and shadow[1] holds the new value. A second commit copies the new value.
- Bounds: write to word NUM_REGS+5 -> no state change and it reads 0. Run 65536 commits (forced) -> counter wraps to 0.
